// File: rtl/uart_pkg.sv
// Shared definitions for the UART transceiver: parity modes,
// RX/TX state encoding and bit-period helper.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } uart_state_t;

   function automatic int clks_per_bit(
      input int clk_hz,
      input int baud
   );
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module uart_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_fifo_loopback.sv
// UART transceiver with RX FIFO, valid/ready host port and an
// internal echo path selected by loop_en.
module uart_fifo_loopback
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 100_000_000,
   parameter int BAUD       = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          rs232_rx,
   output logic                          rs232_tx,
   input  logic                          loop_en,
   input  logic [DATA_BITS-1:0]          tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   rx_count,
   output logic                          parity_err,
   output logic                          frame_err,
   output logic                          overflow
);

   localparam int CPB  = clks_per_bit(CLK_HZ, BAUD);
   localparam int CW   = $clog2(CPB);
   localparam int HALF = CPB / 2;
   localparam logic PAR_EN =
      (PARITY == PAR_ODD) || (PARITY == PAR_EVEN);
   localparam logic ODD_BIT = (PARITY == PAR_ODD);
   localparam logic [CW-1:0] CNT_LAST = CW'(CPB - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
   localparam logic [3:0]    BIT_LAST = 4'(DATA_BITS - 1);

   uart_state_t rx_state, rx_next;
   uart_state_t tx_state, tx_next;

   logic                 rx_s1, rx_s2, rx_prev, rx_armed;
   logic [CW-1:0]        rx_cnt;
   logic [3:0]           rx_bits;
   logic [DATA_BITS-1:0] rx_shift;
   logic                 rx_par_bit;
   logic                 rx_full, rx_half, rx_done;
   logic                 par_ok, rx_good;

   logic [CW-1:0]        tx_cnt;
   logic [3:0]           tx_bits;
   logic [DATA_BITS-1:0] tx_shift;
   logic                 tx_par;
   logic                 tx_full;
   logic                 host_take, loop_take;

   logic                 fifo_pop, fifo_full, fifo_empty;
   logic [DATA_BITS-1:0] fifo_rdata;

   assign rx_full = (rx_cnt == CNT_LAST);
   assign rx_half = (rx_cnt == CNT_HALF);
   assign tx_full = (tx_cnt == CNT_LAST);

   // Receiver arms only once the synchronised line has been high
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_s1    <= 1'b0;
         rx_s2    <= 1'b0;
         rx_prev  <= 1'b0;
         rx_armed <= 1'b0;
      end else begin
         rx_s1    <= rs232_rx;
         rx_s2    <= rx_s1;
         rx_prev  <= rx_s2;
         rx_armed <= rx_armed | rx_s2;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state <= ST_IDLE;
         tx_state <= ST_IDLE;
      end else begin
         rx_state <= rx_next;
         tx_state <= tx_next;
      end
   end

   always_comb begin
      rx_next = rx_state;
      unique case (rx_state)
         ST_IDLE:
            if (rx_armed && rx_prev && !rx_s2)
               rx_next = ST_START;
         ST_START:
            if (rx_half)
               rx_next = rx_s2 ? ST_IDLE : ST_DATA;
         ST_DATA:
            if (rx_full && rx_bits == BIT_LAST)
               rx_next = PAR_EN ? ST_PARITY : ST_STOP;
         ST_PARITY:
            if (rx_full) rx_next = ST_STOP;
         ST_STOP:
            if (rx_full) rx_next = ST_IDLE;
         default: rx_next = ST_IDLE;
      endcase
   end

   always_comb begin
      tx_next = tx_state;
      unique case (tx_state)
         ST_IDLE:
            if (host_take || loop_take)
               tx_next = ST_START;
         ST_START:
            if (tx_full) tx_next = ST_DATA;
         ST_DATA:
            if (tx_full && tx_bits == BIT_LAST)
               tx_next = PAR_EN ? ST_PARITY : ST_STOP;
         ST_PARITY:
            if (tx_full) tx_next = ST_STOP;
         ST_STOP:
            if (tx_full) tx_next = ST_IDLE;
         default: tx_next = ST_IDLE;
      endcase
   end

   always_comb begin
      rx_done   = (rx_state == ST_STOP) && rx_full;
      par_ok    = !PAR_EN ||
                  (rx_par_bit == ((^rx_shift) ^ ODD_BIT));
      rx_good   = rx_done && par_ok && rx_s2;
      tx_ready  = (tx_state == ST_IDLE) && !reset && !loop_en;
      host_take = tx_valid && tx_ready;
      loop_take = (tx_state == ST_IDLE) && loop_en &&
                  !fifo_empty;
      rx_valid  = !fifo_empty && !loop_en;
      fifo_pop  = loop_take || (rx_valid && rx_ready);
      rs232_tx  = 1'b1;
      unique case (tx_state)
         ST_START:  rs232_tx = 1'b0;
         ST_DATA:   rs232_tx = tx_shift[0];
         ST_PARITY: rs232_tx = tx_par;
         default:   rs232_tx = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_cnt     <= '0;
         rx_bits    <= '0;
         rx_shift   <= '0;
         rx_par_bit <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         if (rx_state == ST_IDLE || rx_next != rx_state ||
             rx_full)
            rx_cnt <= '0;
         else
            rx_cnt <= rx_cnt + 1'b1;
         if (rx_state == ST_IDLE)
            rx_bits <= '0;
         else if (rx_state == ST_DATA && rx_full) begin
            rx_bits  <= rx_bits + 1'b1;
            rx_shift <= {rx_s2, rx_shift[DATA_BITS-1:1]};
         end
         if (rx_state == ST_PARITY && rx_full)
            rx_par_bit <= rx_s2;
         parity_err <= rx_done && !par_ok;
         frame_err  <= rx_done && !rx_s2;
         if (rx_good && fifo_full && !fifo_pop)
            overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_cnt   <= '0;
         tx_bits  <= '0;
         tx_shift <= '0;
         tx_par   <= 1'b0;
      end else begin
         if (tx_state == ST_IDLE || tx_next != tx_state ||
             tx_full)
            tx_cnt <= '0;
         else
            tx_cnt <= tx_cnt + 1'b1;
         if (tx_state == ST_IDLE) begin
            tx_bits <= '0;
            if (loop_take) begin
               tx_shift <= fifo_rdata;
               tx_par   <= (^fifo_rdata) ^ ODD_BIT;
            end else if (host_take) begin
               tx_shift <= tx_data;
               tx_par   <= (^tx_data) ^ ODD_BIT;
            end
         end else if (tx_state == ST_DATA && tx_full) begin
            tx_bits  <= tx_bits + 1'b1;
            tx_shift <= tx_shift >> 1;
         end
      end
   end

   uart_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (rx_good),
      .wdata (rx_shift),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (rx_count)
   );

   assign rx_data = fifo_rdata;

endmodule

// File: tb/tb_uart_fifo_loopback.sv
// Directed bench: 16 clocks/bit, even parity, 4-entry FIFO.
// Covers RX, parity/frame errors, overflow, host TX, loopback, glitch, reset.
module tb_uart_fifo_loopback;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       rs232_rx;
   logic       rs232_tx;
   logic       loop_en;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [2:0] rx_count;
   logic       parity_err;
   logic       frame_err;
   logic       overflow;

   int checks = 0;
   int errors = 0;
   int perr_n = 0;
   int ferr_n = 0;

   always #5 clk = ~clk;

   uart_fifo_loopback #(
      .CLK_HZ     (1_600_000),
      .BAUD       (100_000),
      .DATA_BITS  (8),
      .PARITY     (2),
      .FIFO_DEPTH (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rs232_rx   (rs232_rx),
      .rs232_tx   (rs232_tx),
      .loop_en    (loop_en),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .rx_count   (rx_count),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .overflow   (overflow)
   );

   always @(negedge clk) begin
      if (parity_err) perr_n++;
      if (frame_err)  ferr_n++;
   end

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h",
                tag, obs, exp);
      end
   endtask

   task automatic drive_frame(input logic [7:0] d,
                              input logic p,
                              input logic stop);
      rs232_rx = 1'b0;
      repeat (CPB) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
         rs232_rx = d[i];
         repeat (CPB) @(posedge clk);
      end
      rs232_rx = p;
      repeat (CPB) @(posedge clk);
      rs232_rx = stop;
   endtask

   task automatic send_frame(input logic [7:0] d,
                             input logic p,
                             input logic stop);
      drive_frame(d, p, stop);
      repeat (CPB) @(posedge clk);
      rs232_rx = 1'b1;
      repeat (2 * CPB) @(posedge clk);
   endtask

   task automatic pop_one;
      @(negedge clk);
      rx_ready = 1'b1;
      @(posedge clk);
      #1 rx_ready = 1'b0;
   endtask

   // Called just after the edge that starts a TX frame
   task automatic capture(output logic [10:0] bits,
                          output int low);
      bits = '0;
      low  = 0;
      for (int n = 0; n <= 11 * CPB; n++) begin
         @(negedge clk);
         if (n % CPB == CPB / 2 && n < 11 * CPB)
            bits[n / CPB] = rs232_tx;
         if (!tx_ready) low++;
      end
   endtask

   initial begin
      #400000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [10:0] bits;
      int          low;
      int          p0, f0;
      logic        found;
      logic [7:0]  b;

      reset    = 1'b1;
      rs232_rx = 1'b1;
      loop_en  = 1'b0;
      tx_data  = 8'h00;
      tx_valid = 1'b0;
      rx_ready = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("rst_tx", rs232_tx, 1);
      check("rst_tx_ready", tx_ready, 0);
      check("rst_rx_valid", rx_valid, 0);
      check("rst_rx_data", rx_data, 0);
      check("rst_rx_count", rx_count, 0);
      check("rst_perr", parity_err, 0);
      check("rst_ferr", frame_err, 0);
      check("rst_ovf", overflow, 0);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("idle_tx_ready", tx_ready, 1);

      p0 = perr_n; f0 = ferr_n;
      send_frame(8'hC5, 1'b0, 1'b1);
      @(negedge clk);
      check("rx_valid", rx_valid, 1);
      check("rx_data", rx_data, 8'hC5);
      check("rx_count", rx_count, 1);
      check("rx_no_perr", perr_n - p0, 0);
      pop_one();
      @(negedge clk);
      check("rx_pop_count", rx_count, 0);
      check("rx_pop_valid", rx_valid, 0);

      p0 = perr_n; f0 = ferr_n;
      send_frame(8'hC5, 1'b1, 1'b1);
      check("par_err_pulses", perr_n - p0, 1);
      check("par_no_ferr", ferr_n - f0, 0);
      check("par_count", rx_count, 0);

      p0 = perr_n; f0 = ferr_n;
      send_frame(8'h5A, 1'b0, 1'b0);
      check("frm_err_pulses", ferr_n - f0, 1);
      check("frm_no_perr", perr_n - p0, 0);
      check("frm_count", rx_count, 0);

      for (int i = 1; i <= 4; i++) begin
         b = 8'(i);
         send_frame(b, ^b, 1'b1);
      end
      check("ovf_full_count", rx_count, 4);
      check("ovf_not_yet", overflow, 0);
      send_frame(8'h05, 1'b0, 1'b1);
      check("ovf_count", rx_count, 4);
      check("ovf_set", overflow, 1);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         check("ovf_pop_data", rx_data, i);
         pop_one();
      end
      @(negedge clk);
      check("ovf_drained", rx_count, 0);
      check("ovf_sticky", overflow, 1);

      tx_data  = 8'h5A;
      tx_valid = 1'b1;
      check("htx_ready", tx_ready, 1);
      @(posedge clk);
      #1 tx_valid = 1'b0;
      check("htx_start", rs232_tx, 0);
      capture(bits, low);
      check("htx_frame", bits, 11'b1_0_01011010_0);
      check("htx_ready_low", low, 11 * CPB);
      check("htx_ready_back", tx_ready, 1);

      @(negedge clk);
      loop_en = 1'b1;
      #1 check("loop_tx_ready", tx_ready, 0);
      drive_frame(8'h33, 1'b0, 1'b1);
      found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk);
         if (rx_count == 3'd1) found = 1'b1;
      end
      check("loop_fifo_write", found, 1);
      check("loop_rx_valid", rx_valid, 0);
      check("loop_tx_wait", rs232_tx, 1);
      @(posedge clk);
      #1;
      check("loop_tx_start", rs232_tx, 0);
      check("loop_popped", rx_count, 0);
      capture(bits, low);
      check("loop_frame", bits, 11'b1_0_00110011_0);
      loop_en = 1'b0;

      p0 = perr_n; f0 = ferr_n;
      @(negedge clk);
      rs232_rx = 1'b0;
      repeat (CPB / 4) @(posedge clk);
      rs232_rx = 1'b1;
      repeat (3 * CPB) @(posedge clk);
      check("glitch_count", rx_count, 0);
      check("glitch_perr", perr_n - p0, 0);
      check("glitch_ferr", ferr_n - f0, 0);
      send_frame(8'hA5, 1'b0, 1'b1);
      check("post_glitch_count", rx_count, 1);
      check("post_glitch_data", rx_data, 8'hA5);

      @(negedge clk);
      tx_data  = 8'h0F;
      tx_valid = 1'b1;
      @(posedge clk);
      #1 tx_valid = 1'b0;
      repeat (8) @(negedge clk);
      check("mid_tx_low", rs232_tx, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("rst_mid_tx", rs232_tx, 1);
      check("rst_mid_count", rx_count, 0);
      check("rst_mid_ready", tx_ready, 0);
      check("rst_mid_ovf", overflow, 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_rel_ready", tx_ready, 1);
      check("rst_rel_tx", rs232_tx, 1);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
